cnn_error_monitor: RTL and testbench
====================================

# cnn_error_monitor

Synthesizable, parametrised run-time performance and error monitor for the CNN output stream. Compares each valid CNN output word against an expected word and accumulates cycle counts, sample count, sum of squared error, sum of absolute error, per-channel absolute error, worst-case error and in-tolerance match count in hardware. It sits beside the `cnn` core on the output bus and replaces bench-only metric code with a block usable in silicon and in regression benches alike.

## Interface
- DATA_WIDTH, 16: width of output and expected words (signed two's complement)
- NUM_CHANNELS, 30: number of output channels; channel index wraps modulo this
- CNT_WIDTH, 32: width of cycle and sample counters
- ACC_WIDTH, 48: width of SSE/SAE and per-channel accumulators
- TOLERANCE, 0: largest |error| counted as a match
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse: clear metrics, begin a run
- enable  in  1  CNN enable, counted into busy_cycles
- cnn_done  in  1  CNN completion; ends the run
- sample_valid  in  1  output_data/exp_data valid this cycle
- output_data  in  DATA_WIDTH  CNN output word
- exp_data  in  DATA_WIDTH  expected word
- rd_ch  in  $clog2(NUM_CHANNELS)  channel select for ch_sae
- busy  out  1  high in RUN or DRAIN
- report_valid  out  1  one-cycle pulse on entering DONE
- total_cycles, busy_cycles, sample_count  out  CNT_WIDTH  counters
- sse, sae  out  ACC_WIDTH  sum of squared / absolute error
- match_count  out  CNT_WIDTH  samples with |error| <= TOLERANCE
- max_abs_err  out  DATA_WIDTH+1  largest |error| seen
- ch_sae  out  ACC_WIDTH  registered SAE of channel rd_ch
- overflow  out  1  sticky: any accumulator or counter saturated

## Operation
- FSM IDLE -> RUN on start; RUN -> DRAIN on cnn_done; DRAIN -> DONE after 3 cycles; DONE -> RUN on start. start in RUN or DRAIN restarts: metrics cleared, in-flight pipeline flushed, state RUN.
- Entering RUN clears every counter, accumulator, max_abs_err, overflow, channel index and per-channel array.
- Samples accepted only in RUN; sample_valid in IDLE/DRAIN/DONE ignored. Sample and cnn_done in same cycle: sample accepted, then DRAIN.
- Channel index starts at 0, increments per accepted sample, wraps NUM_CHANNELS-1 -> 0; travels with the sample through the pipeline.
- Pipeline: S1 diff = sext(output_data) - sext(exp_data), DATA_WIDTH+1 bits signed; S2 abs = |diff| (DATA_WIDTH+1 unsigned, no overflow) and sq = abs*abs (2*DATA_WIDTH+2 bits); S3 add to sse, sae, ch_sae[ch], update max_abs_err, match_count, sample_count.
- All accumulators and counters saturate at all-ones; saturation sets overflow, which holds until next start or reset.
- total_cycles increments every cycle in RUN and DRAIN; busy_cycles increments in RUN when enable=1.
- Outputs hold final values in DONE and IDLE until next start.

## Timing
- Reset: FSM IDLE; all outputs 0, including busy, report_valid, overflow, ch_sae.
- start at edge N: busy=1 and cleared metrics visible after edge N; first counted cycle is N+1.
- Sample accepted at edge N reflected in sse/sae/sample_count after edge N+3.
- cnn_done at edge N: DRAIN cycles N+1..N+3 (counted), DONE and report_valid=1 after edge N+3, report_valid low after N+4; busy drops with DONE.
- ch_sae registered: valid one cycle after rd_ch changes.
- Reset mid-run: immediate IDLE, all state zeroed, no report_valid.

## Test plan
- Reset then idle 10 cycles with sample_valid=1 -> all outputs 0, busy=0.
- start; 60 samples output=0x00FF, exp=0x00FF; cnn_done -> sample_count=60, sse=sae=0, match_count=60, each ch_sae=0, report_valid one pulse.
- start; 4 samples output=0x0000, exp=0x0003 -> sse=36, sae=12, max_abs_err=3, match_count=0 (TOLERANCE=0); ch_sae[0..3]=3, ch_sae[4]=0.
- Signed extreme: output=0x7FFF, exp=0x8000 -> abs=65535, sq=4294836225 into sse, no overflow.
- Saturation with ACC_WIDTH=20: repeated 0x7FFF/0x8000 pairs -> sse pins at 0xFFFFF, overflow=1 until next start.
- start asserted mid-RUN with samples in flight -> metrics cleared, flushed samples never counted; cnn_done coincident with a sample -> that sample counted, total_cycles = RUN cycles + 3.

Source files
------------

// File: rtl/cnn_error_monitor.sv
// cnn_error_monitor: checks each valid CNN output word against its expected word.
// Over one run (start .. cnn_done + drain) it accumulates cycle, error and match metrics.
module cnn_error_monitor #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 30,
    parameter int CNT_WIDTH    = 32,
    parameter int ACC_WIDTH    = 48,
    parameter int TOLERANCE    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            enable,
    input  logic                            cnn_done,
    input  logic                            sample_valid,
    input  logic [DATA_WIDTH-1:0]           output_data,
    input  logic [DATA_WIDTH-1:0]           exp_data,
    input  logic [$clog2(NUM_CHANNELS)-1:0] rd_ch,
    output logic                            busy,
    output logic                            report_valid,
    output logic [CNT_WIDTH-1:0]            total_cycles,
    output logic [CNT_WIDTH-1:0]            busy_cycles,
    output logic [CNT_WIDTH-1:0]            sample_count,
    output logic [ACC_WIDTH-1:0]            sse,
    output logic [ACC_WIDTH-1:0]            sae,
    output logic [CNT_WIDTH-1:0]            match_count,
    output logic [DATA_WIDTH:0]             max_abs_err,
    output logic [ACC_WIDTH-1:0]            ch_sae,
    output logic                            overflow,
    output logic [1:0]                      state_dbg
);
    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int DW1   = DATA_WIDTH + 1;
    localparam int SQ_W  = 2 * DATA_WIDTH + 2;
    localparam int SUM_W = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    state_t                state;
    logic [1:0]            drain_cnt;
    logic [CH_W-1:0]       ch_idx;
    logic                  s0_valid, s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s0_out, s0_exp;
    logic [CH_W-1:0]       s0_ch, s1_ch, s2_ch;
    logic [DW1-1:0]        s1_diff, s2_abs;
    logic [SQ_W-1:0]       s2_sq;
    logic [ACC_WIDTH-1:0]  ch_acc [NUM_CHANNELS];

    logic [DW1-1:0]   diff_c, abs_c;
    logic [SQ_W-1:0]  sq_c;
    logic [SUM_W-1:0] sse_sum, sae_sum, ch_sum;

    assign state_dbg = state;

    // Differences never reach the most negative DW1 value, so negation cannot overflow.
    always_comb begin
        diff_c  = {s0_out[DATA_WIDTH-1], s0_out} - {s0_exp[DATA_WIDTH-1], s0_exp};
        abs_c   = s1_diff[DW1-1] ? (~s1_diff + DW1'(1)) : s1_diff;
        sq_c    = SQ_W'(abs_c) * SQ_W'(abs_c);
        sse_sum = SUM_W'(sse) + SUM_W'(s2_sq);
        sae_sum = SUM_W'(sae) + SUM_W'(s2_abs);
        ch_sum  = SUM_W'(ch_acc[s2_ch]) + SUM_W'(s2_abs);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            report_valid <= 1'b0;
            drain_cnt    <= '0;
            ch_idx       <= '0;
            total_cycles <= '0;
            busy_cycles  <= '0;
            sample_count <= '0;
            match_count  <= '0;
            sse          <= '0;
            sae          <= '0;
            max_abs_err  <= '0;
            overflow     <= 1'b0;
            ch_sae       <= '0;
            s0_valid     <= 1'b0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            s0_out       <= '0;
            s0_exp       <= '0;
            s0_ch        <= '0;
            s1_ch        <= '0;
            s2_ch        <= '0;
            s1_diff      <= '0;
            s2_abs       <= '0;
            s2_sq        <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) ch_acc[i] <= '0;
        end else begin
            ch_sae <= (32'(rd_ch) < NUM_CHANNELS) ? ch_acc[rd_ch] : '0;
            if (start) begin
                // Restart from any state: clear metrics and drop everything in flight.
                state        <= RUN;
                busy         <= 1'b1;
                report_valid <= 1'b0;
                drain_cnt    <= '0;
                ch_idx       <= '0;
                total_cycles <= '0;
                busy_cycles  <= '0;
                sample_count <= '0;
                match_count  <= '0;
                sse          <= '0;
                sae          <= '0;
                max_abs_err  <= '0;
                overflow     <= 1'b0;
                s0_valid     <= 1'b0;
                s1_valid     <= 1'b0;
                s2_valid     <= 1'b0;
                for (int i = 0; i < NUM_CHANNELS; i++) ch_acc[i] <= '0;
            end else begin
                report_valid <= 1'b0;
                s0_valid     <= (state == RUN) && sample_valid;
                s0_out       <= output_data;
                s0_exp       <= exp_data;
                s0_ch        <= ch_idx;
                s1_valid     <= s0_valid;
                s1_diff      <= diff_c;
                s1_ch        <= s0_ch;
                s2_valid     <= s1_valid;
                s2_abs       <= abs_c;
                s2_sq        <= sq_c;
                s2_ch        <= s1_ch;

                if (state == RUN || state == DRAIN) begin
                    if (total_cycles != '1) total_cycles <= total_cycles + CNT_WIDTH'(1);
                    else overflow <= 1'b1;
                end

                case (state)
                    RUN: begin
                        if (enable) begin
                            if (busy_cycles != '1) busy_cycles <= busy_cycles + CNT_WIDTH'(1);
                            else overflow <= 1'b1;
                        end
                        if (sample_valid)
                            ch_idx <= (ch_idx == CH_W'(NUM_CHANNELS - 1)) ? '0 : ch_idx + CH_W'(1);
                        if (cnn_done) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt == 2'd2) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            report_valid <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase

                if (s2_valid) begin
                    if (sse_sum > ACC_MAX) begin sse <= '1; overflow <= 1'b1; end
                    else sse <= sse_sum[ACC_WIDTH-1:0];
                    if (sae_sum > ACC_MAX) begin sae <= '1; overflow <= 1'b1; end
                    else sae <= sae_sum[ACC_WIDTH-1:0];
                    if (ch_sum > ACC_MAX) begin ch_acc[s2_ch] <= '1; overflow <= 1'b1; end
                    else ch_acc[s2_ch] <= ch_sum[ACC_WIDTH-1:0];
                    if (s2_abs > max_abs_err) max_abs_err <= s2_abs;
                    if (sample_count != '1) sample_count <= sample_count + CNT_WIDTH'(1);
                    else overflow <= 1'b1;
                    if (s2_abs <= DW1'(TOLERANCE)) begin
                        if (match_count != '1) match_count <= match_count + CNT_WIDTH'(1);
                        else overflow <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_error_monitor.sv
// Directed bench for cnn_error_monitor: a default instance and a narrow-accumulator
// instance share one input stream so saturation can be observed side by side.
module tb_cnn_error_monitor;
    logic        clk = 1'b0;
    logic        reset, start, enable, cnn_done, sample_valid;
    logic [15:0] output_data, exp_data;
    logic [4:0]  rd_ch;

    logic        busy, report_valid, overflow;
    logic [31:0] total_cycles, busy_cycles, sample_count, match_count;
    logic [47:0] sse, sae, ch_sae;
    logic [16:0] max_abs_err;
    logic [1:0]  state_dbg;

    logic        busy_s, report_valid_s, overflow_s;
    logic [31:0] total_cycles_s, busy_cycles_s, sample_count_s, match_count_s;
    logic [19:0] sse_s, sae_s, ch_sae_s;
    logic [16:0] max_abs_err_s;
    logic [1:0]  state_dbg_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] o;
        logic [15:0] e;
        logic [63:0] sse;
        logic [63:0] sae;
        logic [63:0] mx;
        logic [63:0] mt;
        logic [63:0] sse_s;
        logic [63:0] ovf_s;
    } vec_t;
    vec_t vecs [7];

    cnn_error_monitor dut (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .cnn_done(cnn_done),
        .sample_valid(sample_valid), .output_data(output_data), .exp_data(exp_data),
        .rd_ch(rd_ch), .busy(busy), .report_valid(report_valid),
        .total_cycles(total_cycles), .busy_cycles(busy_cycles), .sample_count(sample_count),
        .sse(sse), .sae(sae), .match_count(match_count), .max_abs_err(max_abs_err),
        .ch_sae(ch_sae), .overflow(overflow), .state_dbg(state_dbg)
    );

    cnn_error_monitor #(.ACC_WIDTH(20)) dut_s (
        .clk(clk), .reset(reset), .start(start), .enable(enable), .cnn_done(cnn_done),
        .sample_valid(sample_valid), .output_data(output_data), .exp_data(exp_data),
        .rd_ch(rd_ch), .busy(busy_s), .report_valid(report_valid_s),
        .total_cycles(total_cycles_s), .busy_cycles(busy_cycles_s),
        .sample_count(sample_count_s), .sse(sse_s), .sae(sae_s), .match_count(match_count_s),
        .max_abs_err(max_abs_err_s), .ch_sae(ch_sae_s), .overflow(overflow_s),
        .state_dbg(state_dbg_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; enable = 1'b0; cnn_done = 1'b0; sample_valid = 1'b0;
        output_data = '0; exp_data = '0;
    endtask

    task automatic do_start();
        idle_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] o, input logic [15:0] e, input logic en, input logic done);
        sample_valid = 1'b1; output_data = o; exp_data = e; enable = en; cnn_done = done;
        tick();
        idle_inputs();
    endtask

    task automatic read_ch(input int ch, input logic [63:0] exp, input string tag);
        rd_ch = 5'(ch);
        tick();
        chk($sformatf("%s_ch%0d", tag, ch), 64'(ch_sae), exp);
    endtask

    initial begin
        int rv_cnt, rv_at;
        vecs[0] = '{16'h00FF, 16'h00FF, 64'd0,          64'd0,     64'd0,     64'd1, 64'd0,       64'd0};
        vecs[1] = '{16'h0000, 16'h0003, 64'd9,          64'd3,     64'd3,     64'd0, 64'd9,       64'd0};
        vecs[2] = '{16'h7FFF, 16'h8000, 64'd4294836225, 64'd65535, 64'd65535, 64'd0, 64'd1048575, 64'd1};
        vecs[3] = '{16'h8000, 16'h7FFF, 64'd4294836225, 64'd65535, 64'd65535, 64'd0, 64'd1048575, 64'd1};
        vecs[4] = '{16'hFFFF, 16'h0001, 64'd4,          64'd2,     64'd2,     64'd0, 64'd4,       64'd0};
        vecs[5] = '{16'h0064, 16'hFF9C, 64'd40000,      64'd200,   64'd200,   64'd0, 64'd40000,   64'd0};
        vecs[6] = '{16'h1234, 16'h1234, 64'd0,          64'd0,     64'd0,     64'd1, 64'd0,       64'd0};

        // Reset, then idle with garbage samples that must be ignored.
        idle_inputs();
        rd_ch = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1; enable = 1'b1;
            output_data = 16'($urandom_range(0, 65535)); exp_data = 16'($urandom_range(0, 65535));
            tick();
        end
        idle_inputs();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_report", 64'(report_valid), 0);
        chk("rst_total", 64'(total_cycles), 0);
        chk("rst_busy_cycles", 64'(busy_cycles), 0);
        chk("rst_samples", 64'(sample_count), 0);
        chk("rst_sse", 64'(sse), 0);
        chk("rst_sae", 64'(sae), 0);
        chk("rst_match", 64'(match_count), 0);
        chk("rst_max", 64'(max_abs_err), 0);
        chk("rst_ch_sae", 64'(ch_sae), 0);
        chk("rst_overflow", 64'(overflow), 0);
        chk("rst_state", 64'(state_dbg), 0);

        // Single-sample runs from the vector table.
        for (int i = 0; i < 7; i++) begin
            do_start();
            chk($sformatf("v%0d_start_busy", i), 64'(busy), 1);
            chk($sformatf("v%0d_start_samples", i), 64'(sample_count), 0);
            send(vecs[i].o, vecs[i].e, 1'b1, 1'b1);
            tick();
            tick();
            chk($sformatf("v%0d_pre_report", i), 64'(report_valid), 0);
            chk($sformatf("v%0d_latency", i), 64'(sample_count), 0);
            tick();
            chk($sformatf("v%0d_report", i), 64'(report_valid), 1);
            chk($sformatf("v%0d_busy", i), 64'(busy), 0);
            chk($sformatf("v%0d_samples", i), 64'(sample_count), 1);
            chk($sformatf("v%0d_sse", i), 64'(sse), vecs[i].sse);
            chk($sformatf("v%0d_sae", i), 64'(sae), vecs[i].sae);
            chk($sformatf("v%0d_max", i), 64'(max_abs_err), vecs[i].mx);
            chk($sformatf("v%0d_match", i), 64'(match_count), vecs[i].mt);
            chk($sformatf("v%0d_total", i), 64'(total_cycles), 4);
            chk($sformatf("v%0d_busy_cycles", i), 64'(busy_cycles), 1);
            chk($sformatf("v%0d_overflow", i), 64'(overflow), 0);
            chk($sformatf("v%0d_sse_s", i), 64'(sse_s), vecs[i].sse_s);
            chk($sformatf("v%0d_ovf_s", i), 64'(overflow_s), vecs[i].ovf_s);
            tick();
            chk($sformatf("v%0d_report_low", i), 64'(report_valid), 0);
        end

        // 60 matching samples, last one coincident with cnn_done; drain samples ignored.
        do_start();
        for (int i = 0; i < 60; i++) send(16'h00FF, 16'h00FF, (i % 2) == 0, i == 59);
        rv_cnt = 0; rv_at = 0;
        for (int k = 1; k <= 8; k++) begin
            sample_valid = 1'b1; output_data = 16'h0100; exp_data = 16'h0000;
            tick();
            if (report_valid) begin
                rv_cnt++;
                if (rv_at == 0) rv_at = k;
            end
        end
        idle_inputs();
        chk("m60_report_pulses", 64'(rv_cnt), 1);
        chk("m60_report_at", 64'(rv_at), 3);
        chk("m60_samples", 64'(sample_count), 60);
        chk("m60_sse", 64'(sse), 0);
        chk("m60_sae", 64'(sae), 0);
        chk("m60_match", 64'(match_count), 60);
        chk("m60_max", 64'(max_abs_err), 0);
        chk("m60_total", 64'(total_cycles), 63);
        chk("m60_busy_cycles", 64'(busy_cycles), 30);
        chk("m60_busy", 64'(busy), 0);
        for (int c = 0; c < 30; c++) read_ch(c, 0, "m60");

        // Four samples with error -3 each.
        do_start();
        for (int i = 0; i < 4; i++) send(16'h0000, 16'h0003, 1'b1, i == 3);
        repeat (3) tick();
        chk("e3_sse", 64'(sse), 36);
        chk("e3_sae", 64'(sae), 12);
        chk("e3_max", 64'(max_abs_err), 3);
        chk("e3_match", 64'(match_count), 0);
        chk("e3_samples", 64'(sample_count), 4);
        for (int c = 0; c < 5; c++) read_ch(c, (c < 4) ? 64'd3 : 64'd0, "e3");

        // 32 samples wrap the channel index back onto channels 0 and 1.
        do_start();
        for (int i = 0; i < 32; i++) send(16'h0000, 16'h0001, 1'b0, i == 31);
        repeat (3) tick();
        chk("wrap_sae", 64'(sae), 32);
        chk("wrap_sse", 64'(sse), 32);
        chk("wrap_busy_cycles", 64'(busy_cycles), 0);
        read_ch(0, 2, "wrap");
        read_ch(1, 2, "wrap");
        read_ch(2, 1, "wrap");
        read_ch(29, 1, "wrap");
        read_ch(30, 0, "wrap");

        // Extreme pairs: the 20-bit instance saturates, the default one does not.
        do_start();
        for (int i = 0; i < 20; i++) send(16'h7FFF, 16'h8000, 1'b1, i == 19);
        repeat (3) tick();
        chk("sat_sae", 64'(sae), 64'd1310700);
        chk("sat_sse", 64'(sse), 64'd85896724500);
        chk("sat_overflow", 64'(overflow), 0);
        chk("sat_sse_s", 64'(sse_s), 64'hFFFFF);
        chk("sat_sae_s", 64'(sae_s), 64'hFFFFF);
        chk("sat_samples_s", 64'(sample_count_s), 20);
        chk("sat_ovf_s", 64'(overflow_s), 1);
        repeat (2) tick();
        chk("sat_ovf_s_hold", 64'(overflow_s), 1);
        do_start();
        chk("sat_ovf_s_cleared", 64'(overflow_s), 0);
        chk("sat_sse_s_cleared", 64'(sse_s), 0);

        // Restart while two samples are still in the pipeline.
        do_start();
        send(16'h0000, 16'h0005, 1'b1, 1'b0);
        send(16'h0000, 16'h0005, 1'b1, 1'b0);
        do_start();
        chk("rs_busy", 64'(busy), 1);
        chk("rs_total", 64'(total_cycles), 0);
        chk("rs_samples", 64'(sample_count), 0);
        send(16'h0000, 16'h0001, 1'b1, 1'b1);
        repeat (3) tick();
        chk("rs_report", 64'(report_valid), 1);
        chk("rs_final_samples", 64'(sample_count), 1);
        chk("rs_sae", 64'(sae), 1);
        chk("rs_sse", 64'(sse), 1);
        chk("rs_max", 64'(max_abs_err), 1);
        chk("rs_total_final", 64'(total_cycles), 4);

        // Asynchronous reset in the middle of a run.
        do_start();
        for (int i = 0; i < 5; i++) send(16'h0000, 16'h0009, 1'b1, 1'b0);
        chk("mr_samples_before", 64'(sample_count), 2);
        chk("mr_sae_before", 64'(sae), 18);
        #2 reset = 1'b1;
        #1;
        chk("mr_busy", 64'(busy), 0);
        chk("mr_samples", 64'(sample_count), 0);
        chk("mr_sae", 64'(sae), 0);
        chk("mr_total", 64'(total_cycles), 0);
        chk("mr_state", 64'(state_dbg), 0);
        tick();
        reset = 1'b0;
        rv_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (report_valid) rv_cnt++;
        end
        chk("mr_no_report", 64'(rv_cnt), 0);
        chk("mr_idle_total", 64'(total_cycles), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
